jump_physics: RTL and testbench

- Parametrised successor to the dinosaur jump controller. Models the dinosaur's vertical motion with a signed velocity and a constant gravity.
- Contains a game-status FSM (IDLE/PLAYING/OVER), a frame-tick divider and rising-edge jump detection.
- Sits between the button debouncer and the renderer/collision logic, which consume dinosaur_height and game_status.

---
 rtl/jump_physics.sv | 139 +++++++++++++
 tb/tb_jump_physics.sv | 137 +++++++++++++
 2 files changed

// File: rtl/jump_physics.sv
// jump_physics: dinosaur vertical motion with game FSM, tick divider and jump-edge detect.
// Define JUMP_PHYSICS_DOUBLE_JUMP_EN to allow one mid-air relaunch per airtime.
module jump_physics #(
    parameter int HEIGHT_W = 6,
    parameter int VEL_W    = 4,
    parameter int JUMP_VEL = 3,
    parameter int GRAVITY  = 1,
    parameter int TICK_DIV = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                game_start,
    input  logic                game_over,
    input  logic                button_jump,
    output logic [HEIGHT_W-1:0] dinosaur_height,
    output logic                game_status,
    output logic [1:0]          game_state,
    output logic                airborne,
    output logic                landed
);
    localparam int SW = (HEIGHT_W > VEL_W ? HEIGHT_W : VEL_W) + 2;
    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic signed [SW-1:0]    C_HMAX = SW'(2 ** HEIGHT_W - 1);
    localparam logic signed [SW-1:0]    C_VMIN = SW'(-(2 ** (VEL_W - 1)));
    localparam logic signed [SW-1:0]    C_GRAV = SW'(GRAVITY);
    localparam logic signed [VEL_W-1:0] C_JUMP = VEL_W'(JUMP_VEL);

    typedef enum logic [1:0] {IDLE = 2'b00, PLAYING = 2'b01, OVER = 2'b10} game_t;
    typedef enum logic {GROUND = 1'b0, AIR = 1'b1} motion_t;

    game_t                    r_game;
    motion_t                  r_motion;
    logic [HEIGHT_W-1:0]      r_height;
    logic signed [VEL_W-1:0]  r_vel;
    logic [CW-1:0]            r_cnt;
    logic                     r_pending;
    logic                     r_btn_q;
    logic                     r_landed;

    logic                     w_tick;
    logic                     w_edge;
    logic signed [SW-1:0]     w_h_s;
    logic signed [SW-1:0]     w_v_s;
    logic signed [SW-1:0]     w_sum;
    logic signed [SW-1:0]     w_vdec;
    logic                     w_land;
    logic                     w_clamp;
    logic [VEL_W-1:0]         w_vnext;

    assign w_tick  = (r_game == PLAYING) && (r_cnt == CW'(TICK_DIV - 1));
    assign w_edge  = button_jump & ~r_btn_q;
    assign w_h_s   = {{(SW-HEIGHT_W){1'b0}}, r_height};
    assign w_v_s   = {{(SW-VEL_W){r_vel[VEL_W-1]}}, r_vel};
    assign w_sum   = w_h_s + w_v_s;
    assign w_vdec  = w_v_s - C_GRAV;
    assign w_land  = r_vel[VEL_W-1] && (w_h_s <= -w_v_s);
    assign w_clamp = w_sum > C_HMAX;
    assign w_vnext = (w_vdec < C_VMIN) ? C_VMIN[VEL_W-1:0] : w_vdec[VEL_W-1:0];

`ifdef JUMP_PHYSICS_DOUBLE_JUMP_EN
    logic r_dj;
    logic w_air_edge;
    assign w_air_edge = w_edge && (r_motion == AIR) && !r_dj;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_game    <= IDLE;
            r_motion  <= GROUND;
            r_height  <= '0;
            r_vel     <= '0;
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_btn_q   <= 1'b0;
            r_landed  <= 1'b0;
`ifdef JUMP_PHYSICS_DOUBLE_JUMP_EN
            r_dj      <= 1'b0;
`endif
        end else begin
            r_btn_q  <= button_jump;
            r_landed <= 1'b0;
            if (r_game != PLAYING) begin
                r_cnt     <= '0;
                r_pending <= 1'b0;
`ifdef JUMP_PHYSICS_DOUBLE_JUMP_EN
                r_dj      <= 1'b0;
`endif
                if (game_start) begin
                    r_game   <= PLAYING;
                    r_motion <= GROUND;
                    r_height <= '0;
                    r_vel    <= '0;
                end
            end else begin
                if (game_over)
                    r_game <= OVER;
                r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
                if (w_tick) begin
                    if (r_motion == GROUND) begin
                        if (r_pending || w_edge) begin
                            r_vel     <= C_JUMP;
                            r_motion  <= AIR;
                            r_pending <= 1'b0;
                        end
                    end else if (w_land) begin
                        // landing beats any queued mid-air relaunch
                        r_height  <= '0;
                        r_vel     <= '0;
                        r_motion  <= GROUND;
                        r_landed  <= 1'b1;
                        r_pending <= 1'b0;
`ifdef JUMP_PHYSICS_DOUBLE_JUMP_EN
                        r_dj      <= 1'b0;
                    end else if (r_pending || w_air_edge) begin
                        r_vel     <= C_JUMP;
                        r_dj      <= 1'b1;
                        r_pending <= 1'b0;
`endif
                    end else begin
                        r_height <= w_clamp ? '1 : w_sum[HEIGHT_W-1:0];
                        r_vel    <= w_clamp ? '0 : w_vnext;
                    end
                end else if (w_edge && r_motion == GROUND) begin
                    r_pending <= 1'b1;
`ifdef JUMP_PHYSICS_DOUBLE_JUMP_EN
                end else if (w_air_edge) begin
                    r_pending <= 1'b1;
`endif
                end
            end
        end
    end

    assign dinosaur_height = r_height;
    assign game_status     = r_game == PLAYING;
    assign game_state      = r_game;
    assign airborne        = r_motion == AIR;
    assign landed          = r_landed;
endmodule

// File: tb/tb_jump_physics.sv
// tb_jump_physics: scoreboard bench over three parameterisations of jump_physics.
module tb_jump_physics;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] st  = '0;
    logic [2:0] ov  = '0;
    logic [2:0] bt  = '0;
    logic [5:0] h0, h2;
    logic [2:0] h1;
    logic [1:0] gst0, gst1, gst2;
    logic [2:0] gs, air, ld;
    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        int         dut;
        logic [5:0] h;
        logic [1:0] s;
        logic       a;
        logic       l;
    } exp_t;
    exp_t q[$];

    int STD[8] = '{0, 3, 5, 6, 6, 5, 3, 0};
    int CL[8]  = '{0, 7, 7, 7, 6, 4, 1, 0};
    int DJ[13] = '{0, 3, 5, 5, 8, 10, 11, 11, 10, 8, 5, 1, 0};

    jump_physics u0 (
        .CLK(clk), .RST(rst), .game_start(st[0]), .game_over(ov[0]), .button_jump(bt[0]),
        .dinosaur_height(h0), .game_status(gs[0]), .game_state(gst0), .airborne(air[0]), .landed(ld[0])
    );
    jump_physics #(.HEIGHT_W(3), .JUMP_VEL(7)) u1 (
        .CLK(clk), .RST(rst), .game_start(st[1]), .game_over(ov[1]), .button_jump(bt[1]),
        .dinosaur_height(h1), .game_status(gs[1]), .game_state(gst1), .airborne(air[1]), .landed(ld[1])
    );
    jump_physics #(.TICK_DIV(4)) u2 (
        .CLK(clk), .RST(rst), .game_start(st[2]), .game_over(ov[2]), .button_jump(bt[2]),
        .dinosaur_height(h2), .game_status(gs[2]), .game_state(gst2), .airborne(air[2]), .landed(ld[2])
    );

    initial forever #5 clk = ~clk;

    // drive one cycle of stimulus and queue the outputs expected after the next edge
    task automatic cyc(input string name, input int dut, input logic s, input logic o, input logic b,
                       input logic r, input int eh, input logic [1:0] es, input logic ea, input logic el);
        exp_t e;
        @(negedge clk);
        rst = r;
        st = '0;
        ov = '0;
        bt = '0;
        st[dut] = s;
        ov[dut] = o;
        bt[dut] = b;
        e.name = name;
        e.dut = dut;
        e.h = 6'(eh);
        e.s = es;
        e.a = ea;
        e.l = el;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        logic [5:0] ah;
        logic [1:0] as;
        logic ag, aa, al;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                ah = e.dut == 1 ? {3'b0, h1} : e.dut == 2 ? h2 : h0;
                as = e.dut == 1 ? gst1 : e.dut == 2 ? gst2 : gst0;
                ag = gs[e.dut];
                aa = air[e.dut];
                al = ld[e.dut];
                checks++;
                if (ah !== e.h || as !== e.s || ag !== (e.s == 2'b01) || aa !== e.a || al !== e.l) begin
                    errors++;
                    $display("FAIL %s dut%0d: got h=%0d state=%b status=%b air=%b landed=%b, expected h=%0d state=%b status=%b air=%b landed=%b",
                             e.name, e.dut, ah, as, ag, aa, al, e.h, e.s, e.s == 2'b01, e.a, e.l);
                end
            end
        end
    end

    initial begin
        cyc("reset", 0, 0, 0, 0, 1, 0, 2'b00, 0, 0);
        cyc("reset", 0, 0, 0, 0, 1, 0, 2'b00, 0, 0);
        cyc("idle", 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        cyc("start", 0, 1, 0, 0, 0, 0, 2'b01, 0, 0);
        for (int i = 0; i < 8; i++)
            cyc("jump", 0, 0, 0, i == 0, 0, STD[i], 2'b01, i < 7, i == 7);
        cyc("settle", 0, 0, 0, 0, 0, 0, 2'b01, 0, 0);
        for (int i = 0; i < 30; i++)
            cyc("hold", 0, 0, 0, 1, 0, i < 8 ? STD[i] : 0, 2'b01, i < 7, i == 7);
        cyc("release", 0, 0, 0, 0, 0, 0, 2'b01, 0, 0);
`ifdef JUMP_PHYSICS_DOUBLE_JUMP_EN
        for (int i = 0; i < 13; i++)
            cyc("double", 0, 0, 0, i == 0 || i == 3 || i == 6, 0, DJ[i], 2'b01, i < 12, i == 12);
`else
        for (int i = 0; i < 8; i++)
            cyc("air_press", 0, 0, 0, i == 0 || i == 3, 0, STD[i], 2'b01, i < 7, i == 7);
`endif
        cyc("post", 0, 0, 0, 0, 0, 0, 2'b01, 0, 0);
        for (int i = 0; i < 4; i++)
            cyc("rise", 0, 0, 0, i == 0, 0, STD[i], 2'b01, 1, 0);
        cyc("over", 0, 0, 1, 0, 0, 6, 2'b10, 1, 0);
        for (int i = 0; i < 20; i++)
            cyc("frozen", 0, 0, 0, i % 2 == 0, 0, 6, 2'b10, 1, 0);
        cyc("restart", 0, 1, 0, 0, 0, 0, 2'b01, 0, 0);
        for (int i = 0; i < 8; i++)
            cyc("rejump", 0, 0, 0, i == 0, 0, STD[i], 2'b01, i < 7, i == 7);
        cyc("both", 0, 1, 1, 0, 0, 0, 2'b10, 0, 0);
        cyc("restart2", 0, 1, 0, 0, 0, 0, 2'b01, 0, 0);
        cyc("start1", 1, 1, 0, 0, 0, 0, 2'b01, 0, 0);
        for (int i = 0; i < 8; i++)
            cyc("clamp", 1, 0, 0, i == 0, 0, CL[i], 2'b01, i < 7, i == 7);
        cyc("clamp_post", 1, 0, 0, 0, 0, 0, 2'b01, 0, 0);
        cyc("start2", 2, 1, 0, 0, 0, 0, 2'b01, 0, 0);
        for (int i = 1; i <= 15; i++)
            cyc("div4", 2, 0, 0, i == 1, 0, i < 8 ? 0 : i < 12 ? 3 : 5, 2'b01, i >= 4, 0);
        cyc("rst_mid", 2, 0, 0, 0, 1, 0, 2'b00, 0, 0);
        cyc("after_rst", 2, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
